gnn_input_loader: RTL and testbench
===================================

# gnn_input_loader

Upstream feeder for the GNN accelerator `top`. It accepts a serial stream of 5-bit words over a valid/ready handshake and deposits them into holding registers: 16 node features, 16 layer-1 weights and 8 layer-2 weights. Once all 40 words are loaded it presents them in parallel and asserts `in_ready`. It holds the values stable until the downstream stage reports that its outputs are complete, then re-arms for the next graph.

## Interface
Parameters:
- `DATA_W`, default 5: width of one feature or weight word.
- `N_WORDS`, default 40: words per load (16 + 16 + 8). Fixed by the `top` port set; not for override.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `s_data`  in  5  stream word.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts a word this cycle.
- `x_flat`  out  80  features; element k at bits [5k+4:5k].
- `w1_flat`  out  80  layer-1 weights; element k at bits [5k+4:5k].
- `w2_flat`  out  40  layer-2 weights; element k at bits [5k+4:5k].
- `in_ready`  out  1  parallel outputs are complete and stable; drives `top.in_ready`.
- `out_done`  in  1  downstream is finished with the data (AND of all eight `outXY_ready_nodeN`).
- `word_cnt`  out  6  number of words accepted in the current load, 0..40.

## Operation
- Stream order, by word index i:
  - i = 0..15: feature f of node n at i = 4n+f, giving x0_node0, x1_node0, …, x3_node3. Stored in `x_flat` element i.
  - i = 16..31: weight w{a}{b}, b = 4..7, a = 0..3, at i = 16+4(b−4)+a, giving w04, w14, w24, w34, w05, … Stored in `w1_flat` element i−16.
  - i = 32..39: weight w{a}{b}, b = 8..9, a = 4..7, at i = 32+4(b−8)+(a−4), giving w48, w58, w68, w78, w49, … Stored in `w2_flat` element i−32.
- Words are opaque bits. Weights are 5-bit two's complement downstream; the loader performs no arithmetic or sign handling.
- FSM states:
  - IDLE: entered on reset. `s_ready`=0. Moves to LOAD on the next cycle unconditionally.
  - LOAD: `s_ready`=1. Each handshake (`s_valid` && `s_ready` at the clock edge) writes `s_data` to slot `word_cnt` and increments `word_cnt`. The handshake that makes `word_cnt` reach 40 moves the FSM to HOLD.
  - HOLD: `s_ready`=0 and `in_ready`=1; all data registers are frozen. When `out_done`=1 the FSM moves to LOAD with `word_cnt` cleared to 0.
- Data registers are not cleared between loads. Each slot is overwritten when its word arrives again.
- `out_done` is sampled only in HOLD and ignored in IDLE and LOAD.
- `s_valid` is ignored outside LOAD. No words are dropped or buffered: a word is consumed only on a handshake.

## Timing
- Reset values, effective the cycle after `rst` is sampled high: state = IDLE, `s_ready`=0, `in_ready`=0, `word_cnt`=0, and `x_flat`/`w1_flat`/`w2_flat` all 0.
- After `rst` deasserts: one cycle in IDLE, then `s_ready`=1.
- `s_ready` and `in_ready` are registered state decodes. Neither depends combinationally on `s_valid`.
- Load latency:
  - With `s_valid` held high, the 40 handshakes occur on 40 consecutive edges.
  - `in_ready` goes to 1 and `s_ready` to 0 in the cycle immediately after the 40th handshake edge.
  - No 41st word is accepted.
- Release latency: when `out_done`=1 is sampled in HOLD, the following cycle has `in_ready`=0, `s_ready`=1 and `word_cnt`=0.
- Minimum period per graph: 40 load cycles plus 1 HOLD cycle.
- `rst` asserted mid-LOAD or mid-HOLD overrides everything: the FSM returns to IDLE and all registers clear on that edge. A subsequent load restarts at word 0.
- `rst` and a handshake on the same edge: `rst` wins and the word is discarded.

## Test plan
- Reset: hold `rst` for 2 cycles with `s_valid`=1 → all outputs 0. First cycle after release `s_ready`=0; second cycle `s_ready`=1 and `word_cnt`=0.
- Full load, back-to-back, using the demo vector set (x0_node0=5'b00100, …, w79=5'b00110) → `x_flat[4:0]`=5'b00100, `w1_flat[4:0]`=5'b00011 (w04), `w2_flat[39:35]`=5'b00110 (w79), `w2_flat[9:5]`=5'b11111 (w58). `in_ready` rises exactly 1 cycle after the 40th handshake; `word_cnt`=40.
- Bubbles: `s_valid` alternating 1/0 over the same stream → `word_cnt` advances only on handshakes; final contents identical; `in_ready` rises 1 cycle after the 40th handshake (about 80 cycles).
- HOLD protection: in HOLD, drive `s_valid`=1 with 5'b10101 for 10 cycles → `s_ready`=0 and all flat outputs unchanged. Pulse `out_done` for 1 cycle → next cycle `in_ready`=0, `s_ready`=1. A second load with all words = 5'b01010 → every element reads 5'b01010.
- `out_done` held 1 throughout LOAD → ignored. `in_ready` still rises only after word 40, then drops 1 cycle later because `out_done` is sampled in HOLD.
- Reset mid-load after 20 words → next cycle all outputs 0 and `word_cnt`=0. A full reload then produces correct contents, with no residue from the aborted load.

Source files
------------

// File: rtl/gnn_input_loader_if.sv
// Stream-in / parallel-out bundle between the word feeder, the loader and the GNN core.
interface gnn_input_loader_if #(
    parameter int unsigned DATA_W = 5
);
    localparam int unsigned CNT_W = 6;

    logic [DATA_W-1:0]    s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [16*DATA_W-1:0] x_flat;
    logic [16*DATA_W-1:0] w1_flat;
    logic [8*DATA_W-1:0]  w2_flat;
    logic                 in_ready;
    logic                 out_done;
    logic [CNT_W-1:0]     word_cnt;

    // Feeder / downstream side
    modport master (
        output s_data, s_valid, out_done,
        input  s_ready, x_flat, w1_flat, w2_flat, in_ready, word_cnt
    );

    // Loader side
    modport slave (
        input  s_data, s_valid, out_done,
        output s_ready, x_flat, w1_flat, w2_flat, in_ready, word_cnt
    );
endinterface

// File: rtl/gnn_input_loader.sv
// Collects 40 serial words into feature/weight holding registers and presents them
// in parallel until the downstream stage signals it is done with them.
module gnn_input_loader #(
    parameter int unsigned DATA_W  = 5,
    parameter int unsigned N_WORDS = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    gnn_input_loader_if.slave    bus
);
    localparam int unsigned N_X   = 16;
    localparam int unsigned N_W1  = 16;
    localparam int unsigned N_W2  = 8;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              s_ready_q;
    logic              in_ready_q;
    logic              s_ready_d;
    logic              in_ready_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              hs_c;
    logic              last_c;
    logic [DATA_W-1:0] mem_q [N_WORDS];

    // s_ready_q is high only in LOAD, so a handshake implies LOAD
    assign hs_c   = bus.s_valid && s_ready_q;
    assign last_c = (cnt_q == CNT_W'(N_WORDS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: if (hs_c && last_c) state_d = ST_HOLD;
            ST_HOLD: if (bus.out_done) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so the flags are registered decodes
    always_comb begin
        s_ready_d  = 1'b0;
        in_ready_d = 1'b0;
        if (state_d == ST_LOAD) s_ready_d  = 1'b1;
        if (state_d == ST_HOLD) in_ready_d = 1'b1;
    end

    // Handshake flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready_q  <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            s_ready_q  <= s_ready_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Word counter: advances per handshake, cleared on release from HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (hs_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if ((state_q == ST_HOLD) && bus.out_done) begin
            cnt_q <= '0;
        end
    end

    // Holding registers: slot written on its handshake, otherwise kept across loads
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(N_WORDS); k++) begin
                mem_q[k] <= '0;
            end
        end else if (hs_c) begin
            mem_q[cnt_q] <= bus.s_data;
        end
    end

    // Parallel views of the holding registers
    for (genvar k = 0; k < int'(N_X); k++) begin : g_x
        assign bus.x_flat[k*DATA_W +: DATA_W] = mem_q[k];
    end
    for (genvar k = 0; k < int'(N_W1); k++) begin : g_w1
        assign bus.w1_flat[k*DATA_W +: DATA_W] = mem_q[N_X + k];
    end
    for (genvar k = 0; k < int'(N_W2); k++) begin : g_w2
        assign bus.w2_flat[k*DATA_W +: DATA_W] = mem_q[N_X + N_W1 + k];
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.in_ready = in_ready_q;
    assign bus.word_cnt = cnt_q;

endmodule

// File: tb/tb_gnn_input_loader.sv
// Directed-sequence bench with randomized words, checked against a stream-order model.
module tb_gnn_input_loader;
    localparam int NW = 40;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gnn_input_loader_if #(.DATA_W(5)) bus ();

    gnn_input_loader #(.DATA_W(5), .N_WORDS(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [4:0] words [NW];

    // One comparison: counts it, asserts equality, reports on mismatch
    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected parallel contents derived from the node/feature and weight stream order
    task automatic check_contents(input string tag);
        logic [79:0] ex;
        logic [79:0] ew1;
        logic [39:0] ew2;
        ex = '0; ew1 = '0; ew2 = '0;
        for (int n = 0; n < 4; n++)
            for (int f = 0; f < 4; f++)
                ex[5*(4*n+f) +: 5] = words[4*n+f];
        for (int b = 4; b <= 7; b++)
            for (int a = 0; a <= 3; a++)
                ew1[5*(4*(b-4)+a) +: 5] = words[16 + 4*(b-4) + a];
        for (int b = 8; b <= 9; b++)
            for (int a = 4; a <= 7; a++)
                ew2[5*(4*(b-8)+(a-4)) +: 5] = words[32 + 4*(b-8) + (a-4)];
        check({tag, "_x"},  200'(bus.x_flat),  200'(ex));
        check({tag, "_w1"}, 200'(bus.w1_flat), 200'(ew1));
        check({tag, "_w2"}, 200'(bus.w2_flat), 200'(ew2));
    endtask

    // Feed the first n words of the stream, optionally with alternating bubbles
    task automatic do_load(input int n, input bit bubbles, input string tag);
        int idx = 0;
        int cyc = 0;
        bit v;
        bit rdy;
        while (idx < n && cyc < 400) begin
            rdy = bus.s_ready;
            check({tag, "_srdy"}, 200'(rdy), 200'(idx < NW));
            v = bubbles ? (cyc % 2 == 0) : 1'b1;
            bus.s_valid = v;
            bus.s_data  = v ? words[idx] : 5'($urandom);
            @(negedge clk);
            cyc++;
            if (v && rdy) idx++;
            check({tag, "_cnt"},   200'(bus.word_cnt), 200'(idx));
            check({tag, "_inrdy"}, 200'(bus.in_ready), 200'(idx == NW));
        end
        bus.s_valid = 1'b0;
        if (idx < n) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s_timeout: observed %0d words expected %0d", tag, idx, n);
        end
    endtask

    // One-cycle out_done pulse from HOLD, then expect re-armed LOAD
    task automatic release_hold(input string tag);
        bus.out_done = 1'b1;
        @(negedge clk);
        bus.out_done = 1'b0;
        check({tag, "_inrdy"}, 200'(bus.in_ready), 200'(0));
        check({tag, "_srdy"},  200'(bus.s_ready),  200'(1));
        check({tag, "_cnt"},   200'(bus.word_cnt), 200'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_srdy"},  200'(bus.s_ready),  200'(0));
        check({tag, "_inrdy"}, 200'(bus.in_ready), 200'(0));
        check({tag, "_cnt"},   200'(bus.word_cnt), 200'(0));
        check({tag, "_x"},     200'(bus.x_flat),   200'(0));
        check({tag, "_w1"},    200'(bus.w1_flat),  200'(0));
        check({tag, "_w2"},    200'(bus.w2_flat),  200'(0));
    endtask

    initial begin
        logic [79:0] hx;
        logic [79:0] hw1;
        logic [39:0] hw2;

        rst          = 1'b1;
        bus.s_valid  = 1'b1;
        bus.s_data   = 5'($urandom);
        bus.out_done = 1'b0;

        // Reset held two cycles with s_valid high
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;
        check("rel1_srdy", 200'(bus.s_ready), 200'(0));
        @(negedge clk);
        check("rel2_srdy", 200'(bus.s_ready),  200'(1));
        check("rel2_cnt",  200'(bus.word_cnt), 200'(0));

        // Demo stream: random body with the known anchor values
        for (int i = 0; i < NW; i++) words[i] = 5'($urandom);
        words[0]  = 5'b00100;
        words[16] = 5'b00011;
        words[33] = 5'b11111;
        words[39] = 5'b00110;

        do_load(NW, 1'b0, "demo");
        check_contents("demo");
        hx = bus.x_flat; hw1 = bus.w1_flat; hw2 = bus.w2_flat;
        check("demo_x0",  200'(hx[4:0]),    200'(5'b00100));
        check("demo_w04", 200'(hw1[4:0]),   200'(5'b00011));
        check("demo_w79", 200'(hw2[39:35]), 200'(5'b00110));
        check("demo_w58", 200'(hw2[9:5]),   200'(5'b11111));

        // HOLD protection: valid words must be refused for 10 cycles
        bus.s_valid = 1'b1;
        bus.s_data  = 5'b10101;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_srdy", 200'(bus.s_ready), 200'(0));
        end
        bus.s_valid = 1'b0;
        check("hold_inrdy", 200'(bus.in_ready), 200'(1));
        check("hold_cnt",   200'(bus.word_cnt), 200'(NW));
        check_contents("hold");
        release_hold("rel_a");

        // Second load with a constant pattern
        for (int i = 0; i < NW; i++) words[i] = 5'b01010;
        do_load(NW, 1'b0, "const");
        check_contents("const");
        // No 41st word is accepted
        bus.s_valid = 1'b1;
        bus.s_data  = 5'b11111;
        @(negedge clk);
        bus.s_valid = 1'b0;
        check("no41_cnt",   200'(bus.word_cnt), 200'(NW));
        check("no41_inrdy", 200'(bus.in_ready), 200'(1));
        check_contents("no41");
        release_hold("rel_b");

        // Same demo stream with bubbles
        for (int i = 0; i < NW; i++) words[i] = 5'($urandom);
        words[0]  = 5'b00100;
        words[16] = 5'b00011;
        words[33] = 5'b11111;
        words[39] = 5'b00110;
        do_load(NW, 1'b1, "bub");
        check_contents("bub");
        release_hold("rel_c");

        // out_done held through LOAD is ignored until HOLD
        for (int i = 0; i < NW; i++) words[i] = 5'($urandom);
        bus.out_done = 1'b1;
        do_load(NW, 1'b0, "od");
        check_contents("od");
        @(negedge clk);
        bus.out_done = 1'b0;
        check("od_rel_inrdy", 200'(bus.in_ready), 200'(0));
        check("od_rel_srdy",  200'(bus.s_ready),  200'(1));
        check("od_rel_cnt",   200'(bus.word_cnt), 200'(0));
        check_contents("od_kept");

        // Reset after 20 words, coinciding with a handshake
        for (int i = 0; i < NW; i++) words[i] = 5'($urandom);
        do_load(20, 1'b0, "part");
        bus.s_valid = 1'b1;
        bus.s_data  = 5'($urandom);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.s_valid = 1'b0;
        check_all_zero("midrst");
        @(negedge clk);
        check("midrst_srdy", 200'(bus.s_ready),  200'(1));
        check("midrst_cnt",  200'(bus.word_cnt), 200'(0));

        // Full reload after the aborted one
        for (int i = 0; i < NW; i++) words[i] = 5'($urandom);
        do_load(NW, 1'b1, "reload");
        check_contents("reload");
        release_hold("rel_d");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
